rv32i_issue_ctrl: RTL and testbench
===================================

// Module: rv32i_issue_ctrl
// PURPOSE
//  Scoreboard-based issue controller between the rv32i decode stage and execute.
//  Tracks in-flight register writes per architectural register and stalls decode on RAW/WAW hazards or a full in-flight window.
//  Holds one registered issue slot with valid/ready handshake toward execute.
//  Supports pipeline flush (branch/exception) and counts writeback retirements.
// PARAMETERS
//  PAYLOAD_W     128  width of opaque decode payload carried to execute
//  CNT_W         2    width of per-register pending-write counter (max 2^CNT_W-1 writes per reg)
//  MAX_INFLIGHT  4    max total outstanding register writes (1..2^INFL_W-1)
//  INFL_W        3    width of total in-flight counter
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          reset, asynchronous, active-low
//  dec_valid      in   1          decode presents an instruction
//  dec_ready      out  1          controller accepts it (fire = dec_valid & dec_ready)
//  dec_rd         in   5          destination reg (0 = no write)
//  dec_rs1        in   5          source reg 1 (0 = unused)
//  dec_rs2        in   5          source reg 2 (0 = unused)
//  dec_payload    in   PAYLOAD_W  decode pipe contents, passed through untouched
//  iss_valid      out  1          issue slot holds an instruction for execute
//  iss_ready      in   1          execute accepts (iss fire = iss_valid & iss_ready)
//  iss_rd         out  5          registered copy of dec_rd
//  iss_payload    out  PAYLOAD_W  registered copy of dec_payload
//  wb_valid       in   1          writeback retires a register write
//  wb_rd          in   5          register written back
//  flush          in   1          kill all in-flight and slot contents
//  stall_o        out  1          dec_valid & ~dec_ready (perf/debug)
//  inflight_o     out  INFL_W     current total outstanding writes
//  sb_err_o       out  1          sticky: wb_rd retired with pending count 0
// BEHAVIOUR
//  Reset: iss_valid=0, iss_rd=0, iss_payload=0, all counters 0, inflight_o=0, sb_err_o=0, FSM=RUN.
//  FSM RUN: normal issue. flush -> FLUSH. FLUSH: dec_ready=0 for exactly one cycle, then RUN (flush held high keeps FLUSH).
//  hazard = (rs1!=0 & cnt[rs1]!=0) | (rs2!=0 & cnt[rs2]!=0) | (rd!=0 & cnt[rd]==max) | (rd!=0 & inflight==MAX_INFLIGHT).
//  dec_ready = (state==RUN) & ~flush & ~hazard & (~iss_valid | iss_ready). Combinational; no dependency on dec_valid.
//  Latency: accepted instruction appears on iss_* the next cycle; slot holds stable while iss_valid & ~iss_ready.
//  Slot: fire loads slot; iss fire without dec fire clears iss_valid; both same cycle -> slot reloaded, iss_valid stays 1.
//  Counters: fire with rd!=0 -> cnt[rd]+1, inflight+1; wb_valid with wb_rd!=0 & cnt!=0 -> cnt[wb_rd]-1, inflight-1.
//  Same-cycle fire and wb on same rd: cnt unchanged; inflight unchanged. x0 never tracked.
//  wb_valid with cnt[wb_rd]==0 (wb_rd!=0): no decrement, sb_err_o set until reset.
//  flush (priority over all): next cycle iss_valid=0, all cnt=0, inflight=0; same-cycle fire and wb ignored.
//  Reset mid-operation: immediate async return to reset values regardless of handshake state.
// CONFIGURATION
//  RV32I_ISSUE_BYPASS_EN defined: wb_valid with wb_rd==rs1/rs2 and cnt==1 same cycle removes that RAW hazard (issue same cycle as writeback).
//  Not defined: hazard evaluated on registered counts only; dependent instruction issues one cycle after writeback.
// TESTING
//  Reset then dec_valid, rd=5 rs1=0 rs2=0 -> dec_ready=1, next cycle iss_valid=1 iss_rd=5, cnt[5]=1, inflight_o=1.
//  Issue rd=5, then rs1=5 with no wb -> dec_ready=0, stall_o=1; wb_rd=5 -> issues next cycle (same cycle if BYPASS_EN).
//  Issue 4 instrs rd=1..4, iss_ready=1, no wb -> 5th with rd=6 stalls, inflight_o=4; wb_rd=1 -> 5th accepted.
//  iss_ready=0 with slot full -> dec_ready=0 and iss_payload stable for 3 cycles; iss_ready=1 & dec_valid -> slot reloads, iss_valid stays 1.
//  inflight=3, flush=1 with concurrent dec_valid and wb -> next cycle iss_valid=0, inflight_o=0, dec_ready=0 one cycle, then 1.
//  wb_valid wb_rd=9 with cnt[9]=0 -> sb_err_o=1 held; inflight_o unchanged; rd=0 issues never change counters.

Source files
------------

// File: rtl/rv32i_issue_ctrl.sv
// rv32i_issue_ctrl: scoreboarded decode->execute issue slot with flush.
// Define RV32I_ISSUE_BYPASS_EN to let a same-cycle writeback clear a RAW hazard.
module rv32i_issue_ctrl #(
  parameter int PAYLOAD_W    = 128,
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int INFL_W       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [4:0]           dec_rd,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [4:0]           iss_rd,
  output logic [PAYLOAD_W-1:0] iss_payload,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_rd,
  input  logic                 flush,
  output logic                 stall_o,
  output logic [INFL_W-1:0]    inflight_o,
  output logic                 sb_err_o
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [INFL_W-1:0] INFL_MAX = INFL_W'(MAX_INFLIGHT);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q [32];
  logic [INFL_W-1:0]      inflight_q;
  logic [INFL_W-1:0]      inflight_d;
  logic                   iss_valid_q;
  logic [4:0]             iss_rd_q;
  logic [PAYLOAD_W-1:0]   iss_payload_q;
  logic                   sb_err_q;

  logic [CNT_W-1:0] c_rs1;
  logic [CNT_W-1:0] c_rs2;
  logic [CNT_W-1:0] c_rd;
  logic [CNT_W-1:0] c_wb;
  logic             byp1;
  logic             byp2;
  logic             haz_rs1;
  logic             haz_rs2;
  logic             haz_rd;
  logic             hazard;
  logic             slot_free;
  logic             dec_fire;
  logic             iss_fire;
  logic             wr_fire;
  logic             wb_hit;
  logic             wb_dec;
  logic             wb_err;

  assign c_rs1 = cnt_q[dec_rs1];
  assign c_rs2 = cnt_q[dec_rs2];
  assign c_rd  = cnt_q[dec_rd];
  assign c_wb  = cnt_q[wb_rd];

`ifdef RV32I_ISSUE_BYPASS_EN
  // last pending write retiring now: operand comes from the writeback
  assign byp1 = wb_valid & (wb_rd == dec_rs1) & (c_rs1 == CNT_ONE);
  assign byp2 = wb_valid & (wb_rd == dec_rs2) & (c_rs2 == CNT_ONE);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign haz_rs1 = (dec_rs1 != 5'd0) & (c_rs1 != '0) & ~byp1;
  assign haz_rs2 = (dec_rs2 != 5'd0) & (c_rs2 != '0) & ~byp2;
  assign haz_rd  = (dec_rd != 5'd0) &
                   ((c_rd == CNT_MAX) | (inflight_q == INFL_MAX));
  assign hazard  = haz_rs1 | haz_rs2 | haz_rd;

  assign slot_free = ~iss_valid_q | iss_ready;
  assign dec_ready = (state_q == RUN) & ~flush & ~hazard & slot_free;
  assign dec_fire  = dec_valid & dec_ready;
  assign iss_fire  = iss_valid_q & iss_ready;
  assign wr_fire   = dec_fire & (dec_rd != 5'd0);

  assign wb_hit = wb_valid & (wb_rd != 5'd0);
  assign wb_dec = wb_hit & (c_wb != '0);
  assign wb_err = wb_hit & (c_wb == '0);

  always_comb begin
    inflight_d = inflight_q;
    if (flush) begin
      inflight_d = '0;
    end else begin
      inflight_d = inflight_q + INFL_W'(wr_fire) - INFL_W'(wb_dec);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      unique case (state_q)
        RUN:     if (flush) state_q <= FLUSH;
        FLUSH:   if (!flush) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q   <= 1'b0;
      iss_rd_q      <= 5'd0;
      iss_payload_q <= '0;
    end else if (flush) begin
      iss_valid_q   <= 1'b0;
    end else if (dec_fire) begin
      iss_valid_q   <= 1'b1;
      iss_rd_q      <= dec_rd;
      iss_payload_q <= dec_payload;
    end else if (iss_fire) begin
      iss_valid_q   <= 1'b0;
    end
  end

  // a fire and a retire on the same register cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if ((wr_fire && dec_rd == 5'(i)) &&
            !(wb_dec && wb_rd == 5'(i))) begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end else if ((wb_dec && wb_rd == 5'(i)) &&
                     !(wr_fire && dec_rd == 5'(i))) begin
          cnt_q[i] <= cnt_q[i] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (!flush && wb_err) sb_err_q <= 1'b1;
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_rd      = iss_rd_q;
  assign iss_payload = iss_payload_q;
  assign stall_o     = dec_valid & ~dec_ready;
  assign inflight_o  = inflight_q;
  assign sb_err_o    = sb_err_q;

endmodule

// File: tb/tb_rv32i_issue_ctrl.sv
// tb_rv32i_issue_ctrl: directed scenarios plus random traffic
// checked every cycle against a scoreboard model.
module tb_rv32i_issue_ctrl;
  localparam int PW = 128;
`ifdef RV32I_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dec_valid = 1'b0;
  logic          dec_ready;
  logic [4:0]    dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
  logic [PW-1:0] dec_payload = '0;
  logic          iss_valid;
  logic          iss_ready = 1'b0;
  logic [4:0]    iss_rd;
  logic [PW-1:0] iss_payload;
  logic          wb_valid = 1'b0;
  logic [4:0]    wb_rd = '0;
  logic          flush = 1'b0;
  logic          stall_o;
  logic [2:0]    inflight_o;
  logic          sb_err_o;

  rv32i_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_payload(dec_payload),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rd(iss_rd), .iss_payload(iss_payload),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall_o(stall_o), .inflight_o(inflight_o), .sb_err_o(sb_err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: pending writes per register, total, slot contents
  int            m_cnt [32];
  int            m_infl;
  bit            m_err, m_iv, m_fl;
  logic [4:0]    m_rd;
  logic [PW-1:0] m_pl;

  task automatic chk(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_infl = 0; m_err = 0; m_iv = 0; m_fl = 0; m_rd = '0; m_pl = '0;
  endfunction

  function automatic bit src_busy(logic [4:0] rs);
    if (rs == 0 || m_cnt[rs] == 0) return 1'b0;
    if (BYP && wb_valid && wb_rd == rs && m_cnt[rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    bit h;
    h = src_busy(dec_rs1) || src_busy(dec_rs2) ||
        (dec_rd != 0 && (m_cnt[dec_rd] == 3 || m_infl == 4));
    return !m_fl && !flush && !h && (!m_iv || iss_ready);
  endfunction

  initial m_reset();
  always @(negedge rst_n) m_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      bit fire;
      fire = dec_valid && m_ready();
      if (flush) begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_infl = 0; m_iv = 0; m_fl = 1;
      end else begin
        m_fl = 0;
        if (fire) begin
          m_iv = 1; m_rd = dec_rd; m_pl = dec_payload;
        end else if (m_iv && iss_ready) begin
          m_iv = 0;
        end
        if (wb_valid && wb_rd != 0) begin
          if (m_cnt[wb_rd] > 0) begin
            m_cnt[wb_rd]--; m_infl--;
          end else begin
            m_err = 1;
          end
        end
        if (fire && dec_rd != 0) begin
          m_cnt[dec_rd]++; m_infl++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("dec_ready", PW'(dec_ready), PW'(m_ready()));
      chk("stall_o", PW'(stall_o), PW'(dec_valid && !m_ready()));
      chk("iss_valid", PW'(iss_valid), PW'(m_iv));
      if (m_iv) begin
        chk("iss_rd", PW'(iss_rd), PW'(m_rd));
        chk("iss_payload", iss_payload, m_pl);
      end
      chk("inflight_o", PW'(inflight_o), PW'(m_infl));
      chk("sb_err_o", PW'(sb_err_o), PW'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic dec(bit v, int rd, int rs1, int rs2);
    dec_valid = v;
    dec_rd = 5'(rd); dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2);
    dec_payload = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wb(bit v, int rd);
    wb_valid = v; wb_rd = 5'(rd);
  endtask

  function automatic int pick_wb();
    int off;
    off = $urandom_range(0, 31);
    for (int i = 0; i < 32; i++)
      if (((i + off) % 32) != 0 && m_cnt[(i + off) % 32] > 0)
        return (i + off) % 32;
    return -1;
  endfunction

  logic [PW-1:0] pa;

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    at_neg();
    chk("rst iss_valid", PW'(iss_valid), PW'(0));
    chk("rst iss_rd", PW'(iss_rd), PW'(0));
    chk("rst iss_payload", iss_payload, PW'(0));
    chk("rst inflight", PW'(inflight_o), PW'(0));
    chk("rst sb_err", PW'(sb_err_o), PW'(0));
    step();

    // first issue
    iss_ready = 1; dec(1, 5, 0, 0);
    at_neg(); chk("t1 ready", PW'(dec_ready), PW'(1));
    step(); dec(0, 0, 0, 0);
    chk("t1 iss_valid", PW'(iss_valid), PW'(1));
    chk("t1 iss_rd", PW'(iss_rd), PW'(5));
    chk("t1 inflight", PW'(inflight_o), PW'(1));

    // RAW on x5
    dec(1, 6, 5, 0);
    at_neg();
    chk("t2 ready", PW'(dec_ready), PW'(0));
    chk("t2 stall", PW'(stall_o), PW'(1));
    step(); wb(1, 5);
    at_neg(); chk("t2 wb ready", PW'(dec_ready), PW'(BYP));
    step(); wb(0, 0);
    if (!BYP) begin
      at_neg(); chk("t2 late ready", PW'(dec_ready), PW'(1));
      step();
    end
    dec(0, 0, 0, 0);
    chk("t2 inflight", PW'(inflight_o), PW'(1));
    wb(1, 6); step(); wb(0, 0);

    // window full
    for (int i = 1; i <= 4; i++) begin
      dec(1, i, 0, 0); step();
    end
    dec(1, 6, 0, 0);
    at_neg();
    chk("t3 full ready", PW'(dec_ready), PW'(0));
    chk("t3 inflight", PW'(inflight_o), PW'(4));
    step(); wb(1, 1);
    step(); wb(0, 0);
    at_neg(); chk("t3 ready", PW'(dec_ready), PW'(1));
    step(); dec(0, 0, 0, 0);
    for (int i = 2; i <= 6; i++) if (i != 5) begin
      wb(1, i); step();
    end
    wb(0, 0);

    // backpressure
    iss_ready = 0; dec(1, 0, 0, 0); pa = dec_payload;
    step(); dec(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t4 ready", PW'(dec_ready), PW'(0));
      chk("t4 payload", iss_payload, pa);
      step();
    end
    iss_ready = 1; pa = dec_payload;
    at_neg(); chk("t4 reload ready", PW'(dec_ready), PW'(1));
    step(); dec(0, 0, 0, 0);
    chk("t4 iss_valid", PW'(iss_valid), PW'(1));
    chk("t4 payload B", iss_payload, pa);
    chk("t4 rd0 inflight", PW'(inflight_o), PW'(0));
    step();

    // flush
    for (int i = 1; i <= 3; i++) begin
      dec(1, i, 0, 0); step();
    end
    chk("t5 inflight", PW'(inflight_o), PW'(3));
    dec(1, 7, 0, 0); wb(1, 1); flush = 1;
    step(); flush = 0; wb(0, 0);
    chk("t5 iss_valid", PW'(iss_valid), PW'(0));
    chk("t5 inflight", PW'(inflight_o), PW'(0));
    at_neg(); chk("t5 ready0", PW'(dec_ready), PW'(0));
    step();
    at_neg(); chk("t5 ready1", PW'(dec_ready), PW'(1));
    step(); dec(0, 0, 0, 0);
    wb(1, 7); step(); wb(0, 0);

    // spurious retire
    wb(1, 9); step(); wb(0, 0);
    chk("t6 sb_err", PW'(sb_err_o), PW'(1));
    chk("t6 inflight", PW'(inflight_o), PW'(0));
    step();
    chk("t6 sb_err held", PW'(sb_err_o), PW'(1));

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      int w;
      dec($urandom_range(0, 9) < 8, $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 7));
      iss_ready = $urandom_range(0, 9) < 7;
      w = pick_wb();
      if ($urandom_range(0, 49) == 0) wb(1, $urandom_range(0, 15));
      else if (w > 0) wb($urandom_range(0, 9) < 5, w);
      else wb(0, 0);
      flush = $urandom_range(0, 49) == 0;
      if (c == 1500) begin
        @(posedge clk); #3 rst_n = 0;
        #1;
        chk("arst iss_valid", PW'(iss_valid), PW'(0));
        chk("arst payload", iss_payload, PW'(0));
        chk("arst inflight", PW'(inflight_o), PW'(0));
        chk("arst sb_err", PW'(sb_err_o), PW'(0));
        @(posedge clk); #2 rst_n = 1;
      end
      step();
    end
    dec(0, 0, 0, 0); wb(0, 0); flush = 0;
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
